// File: rtl/seg_pkg.sv
// Shared constants for the MM:SS multiplexed display: segment patterns, slot indices,
// default dividers and the divider-free binary-to-BCD split used for each field.
package seg_pkg;

   localparam int DEF_REFRESH_DIV = 100000;
   localparam int DEF_BLINK_DIV   = 25000000;

   localparam logic [1:0] DIG_SEC_ONES = 2'd0;
   localparam logic [1:0] DIG_SEC_TENS = 2'd1;
   localparam logic [1:0] DIG_MIN_ONES = 2'd2;
   localparam logic [1:0] DIG_MIN_TENS = 2'd3;

   // Active-low cathodes ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd11;

   typedef struct packed {
      logic       valid;
      logic [2:0] tens;
      logic [3:0] ones;
   } field_split_t;

   // Compare/subtract chain instead of a divider; values above 59 are flagged invalid
   function automatic field_split_t splitField(input logic [5:0] value);
      field_split_t split;
      logic [5:0]   rem;
      split.valid = (value <= 6'd59);
      split.tens  = 3'd0;
      rem         = value;
      if (value >= 6'd50) begin
         split.tens = 3'd5;
         rem        = value - 6'd50;
      end else if (value >= 6'd40) begin
         split.tens = 3'd4;
         rem        = value - 6'd40;
      end else if (value >= 6'd30) begin
         split.tens = 3'd3;
         rem        = value - 6'd30;
      end else if (value >= 6'd20) begin
         split.tens = 3'd2;
         rem        = value - 6'd20;
      end else if (value >= 6'd10) begin
         split.tens = 3'd1;
         rem        = value - 6'd10;
      end
      split.ones = rem[3:0];
      return split;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low segment lookup; 10 is a dash, 11 and above blank.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] segments
);

   always_comb begin
      segments = SEG_BLANK;
      case (code)
         4'd0:      segments = SEG_0;
         4'd1:      segments = SEG_1;
         4'd2:      segments = SEG_2;
         4'd3:      segments = SEG_3;
         4'd4:      segments = SEG_4;
         4'd5:      segments = SEG_5;
         4'd6:      segments = SEG_6;
         4'd7:      segments = SEG_7;
         4'd8:      segments = SEG_8;
         4'd9:      segments = SEG_9;
         CODE_DASH: segments = SEG_DASH;
         default:   segments = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit MM:SS scanner: one anode per refresh slot, values snapshotted once per frame,
// and the field under adjustment blinks while adjust is held.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = DEF_REFRESH_DIV,
   parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
   input  logic       timer,
   input  logic       reset,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       adjust,
   input  logic       select,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [REF_W-1:0] refreshCount;
   logic [BLK_W-1:0] blinkCount;
   logic             blinkVisible;
   logic [1:0]       digitIndex;
   logic [5:0]       minSnap;
   logic [5:0]       secSnap;
   logic             scanTick;
   field_split_t     minSplit;
   field_split_t     secSplit;
   field_split_t     curSplit;
   logic             onMinutes;
   logic             onTens;
   logic             slotBlank;
   logic [3:0]       digitCode;
   logic [6:0]       nextSeg;
   logic [3:0]       nextAn;

   assign scanTick = (refreshCount == REF_LAST);

   // Slot timing; inputs are captured only as the index wraps so a frame never tears
   always_ff @(posedge timer or posedge reset) begin
      if (reset) begin
         refreshCount <= '0;
         digitIndex   <= DIG_SEC_ONES;
         minSnap      <= '0;
         secSnap      <= '0;
      end else if (scanTick) begin
         refreshCount <= '0;
         digitIndex   <= digitIndex + 2'd1;
         if (digitIndex == DIG_MIN_TENS) begin
            minSnap <= minutes;
            secSnap <= seconds;
         end
      end else begin
         refreshCount <= refreshCount + REF_W'(1);
      end
   end

   // Blink phase only advances in adjust mode and always restarts visible
   always_ff @(posedge timer or posedge reset) begin
      if (reset) begin
         blinkCount   <= '0;
         blinkVisible <= 1'b1;
      end else if (!adjust) begin
         blinkCount   <= '0;
         blinkVisible <= 1'b1;
      end else if (blinkCount == BLK_LAST) begin
         blinkCount   <= '0;
         blinkVisible <= ~blinkVisible;
      end else begin
         blinkCount <= blinkCount + BLK_W'(1);
      end
   end

   // Blanking looks at adjust directly so releasing adjust relights on the very next update
   always_comb begin
      minSplit  = splitField(minSnap);
      secSplit  = splitField(secSnap);
      onMinutes = (digitIndex == DIG_MIN_ONES) || (digitIndex == DIG_MIN_TENS);
      onTens    = (digitIndex == DIG_SEC_TENS) || (digitIndex == DIG_MIN_TENS);
      curSplit  = onMinutes ? minSplit : secSplit;
      slotBlank = adjust && !blinkVisible && (select != onMinutes);
      if (slotBlank) begin
         digitCode = CODE_BLANK;
      end else if (!curSplit.valid) begin
         digitCode = CODE_DASH;
      end else if (onTens) begin
         digitCode = {1'b0, curSplit.tens};
      end else begin
         digitCode = curSplit.ones;
      end
      nextAn = slotBlank ? 4'b1111 : ~(4'b0001 << digitIndex);
   end

   seg7_decode decodeInst (
      .code     (digitCode),
      .segments (nextSeg)
   );

   // Registered drivers keep the pins glitch-free
   always_ff @(posedge timer or posedge reset) begin
      if (reset) begin
         seg <= SEG_BLANK;
         an  <= 4'b1111;
      end else begin
         seg <= nextSeg;
         an  <= nextAn;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with small dividers: the stimulus queues the expected
// pins for each upcoming clock and a monitor compares them just after that edge.
module tb_seg_scan_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [3:0] AN0   = 4'b1110;
   localparam logic [3:0] AN1   = 4'b1101;
   localparam logic [3:0] AN2   = 4'b1011;
   localparam logic [3:0] AN3   = 4'b0111;
   localparam logic [3:0] ANOFF = 4'b1111;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      string      name;
   } exp_t;

   logic       timer;
   logic       reset;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       adjust;
   logic       select;
   logic [6:0] seg;
   logic [3:0] an;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   seg_scan_display #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
      .timer   (timer),
      .reset   (reset),
      .minutes (minutes),
      .seconds (seconds),
      .adjust  (adjust),
      .select  (select),
      .seg     (seg),
      .an      (an)
   );

   initial timer = 1'b0;
   always #5 timer = ~timer;

   task automatic applyStimulus(input int m, input int s, input logic adj, input logic sel);
      minutes = 6'(m);
      seconds = 6'(s);
      adjust  = adj;
      select  = sel;
   endtask

   task automatic checkOutput(input logic [3:0] expAn, input logic [6:0] expSeg, input string name);
      total++;
      if (an !== expAn || seg !== expSeg) begin
         bad++;
         $display("[TB] FAIL %s: got an=%b seg=%b, expected an=%b seg=%b", name, an, seg, expAn, expSeg);
      end
   endtask

   task automatic expectCycle(input logic [3:0] a, input logic [6:0] s, input string name);
      exp_t e;
      e.an   = a;
      e.seg  = s;
      e.name = name;
      expQ.push_back(e);
      @(negedge timer);
   endtask

   task automatic expectSlot(input logic [3:0] a, input logic [6:0] s, input string name, input int n);
      repeat (n) expectCycle(a, s, name);
   endtask

   task automatic expectFrame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input string name);
      expectSlot(AN0, s0, name, 4);
      expectSlot(AN1, s1, name, 4);
      expectSlot(AN2, s2, name, 4);
      expectSlot(AN3, s3, name, 4);
   endtask

   always begin
      @(posedge timer);
      #2;
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkOutput(e.an, e.seg, e.name);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      applyStimulus(12, 34, 1'b0, 1'b0);
      @(negedge timer);
      expectSlot(ANOFF, BLANK, "reset_hold", 2);
      reset = 1'b0;

      expectFrame(S0, S0, S0, S0, "first_frame_zero");

      expectSlot(AN0, S4, "scan_sec_ones", 4);
      expectCycle(AN1, S3, "scan_sec_tens");
      applyStimulus(12, 35, 1'b0, 1'b0);
      expectSlot(AN1, S3, "tear_sec_tens", 3);
      expectSlot(AN2, S2, "scan_min_ones", 4);
      expectSlot(AN3, S1, "scan_min_tens", 4);

      expectCycle(AN0, S5, "new_sec_ones");
      applyStimulus(59, 60, 1'b0, 1'b0);
      expectSlot(AN0, S5, "new_sec_ones", 3);
      expectSlot(AN1, S3, "new_sec_tens", 4);
      expectSlot(AN2, S2, "new_min_ones", 4);
      expectSlot(AN3, S1, "new_min_tens", 4);

      expectCycle(AN0, DASH, "range_sec_ones");
      applyStimulus(59, 7, 1'b0, 1'b0);
      expectSlot(AN0, DASH, "range_sec_ones", 3);
      expectSlot(AN1, DASH, "range_sec_tens", 4);
      expectSlot(AN2, S9, "range_min_ones", 4);
      expectSlot(AN3, S5, "range_min_tens", 4);

      expectFrame(S7, S0, S9, S5, "frame_59_07");

      applyStimulus(59, 7, 1'b1, 1'b1);
      expectFrame(S7, S0, S9, S5, "blink_visible1");
      expectSlot(ANOFF, BLANK, "blink_sec_off", 8);
      applyStimulus(59, 7, 1'b1, 1'b0);
      expectSlot(ANOFF, BLANK, "blink_min_off", 8);
      applyStimulus(59, 7, 1'b1, 1'b1);
      expectFrame(S7, S0, S9, S5, "blink_visible2");
      expectSlot(ANOFF, BLANK, "blink_sec_off2", 2);
      applyStimulus(59, 7, 1'b0, 1'b1);
      expectSlot(AN0, S7, "adjust_drop", 2);
      expectSlot(AN1, S0, "after_drop", 4);
      expectSlot(AN2, S9, "after_drop", 4);
      expectSlot(AN3, S5, "after_drop", 4);

      expectSlot(AN0, S7, "pre_reset", 4);
      expectSlot(AN1, S0, "pre_reset", 4);
      expectSlot(AN2, S9, "pre_reset", 2);
      reset = 1'b1;
      #1;
      checkOutput(ANOFF, BLANK, "async_reset");
      applyStimulus(12, 34, 1'b0, 1'b0);
      expectSlot(ANOFF, BLANK, "reset_mid", 2);
      reset = 1'b0;

      expectFrame(S0, S0, S0, S0, "restart_zero");
      expectFrame(S4, S3, S2, S1, "restart_frame");

      for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge timer);
      if (expQ.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
